// File: rtl/fft4_in_collector_if.sv
// Sample-in / frame-out bundle between the sample source, the collector and the butterfly.
// The slave modport is the collector's view; master is the driving environment.
interface fft4_in_collector_if #(
    parameter int DATA_W = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic                     s_first;
    logic signed [DATA_W-1:0] s_real;
    logic signed [DATA_W-1:0] s_imag;
    logic signed [DATA_W-1:0] real_out_0;
    logic signed [DATA_W-1:0] real_out_1;
    logic signed [DATA_W-1:0] real_out_2;
    logic signed [DATA_W-1:0] real_out_3;
    logic signed [DATA_W-1:0] imag_out_0;
    logic signed [DATA_W-1:0] imag_out_1;
    logic signed [DATA_W-1:0] imag_out_2;
    logic signed [DATA_W-1:0] imag_out_3;
    logic                     out_valid;
    logic                     out_ready;
    logic                     err_align;

    modport slave (
        input  s_valid, s_first, s_real, s_imag, out_ready,
        output s_ready, out_valid, err_align,
        output real_out_0, real_out_1, real_out_2, real_out_3,
        output imag_out_0, imag_out_1, imag_out_2, imag_out_3
    );

    modport master (
        output s_valid, s_first, s_real, s_imag, out_ready,
        input  s_ready, out_valid, err_align,
        input  real_out_0, real_out_1, real_out_2, real_out_3,
        input  imag_out_0, imag_out_1, imag_out_2, imag_out_3
    );
endinterface

// File: rtl/fft4_in_collector.sv
// Collects four complex samples into a frame for the 4-point butterfly (fill bank + output bank).
// Latency: frame visible one cycle after the edge accepting its last sample.
// Backpressure: s_ready drops only while a complete frame waits behind an undrained output bank.
module fft4_in_collector #(
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft4_in_collector_if.slave   bus
);
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } sample_t;

    sample_t    fill_bank [4];
    sample_t    out_bank  [4];
    sample_t    frame     [4];
    sample_t    in_smp;
    logic [1:0] count;
    logic [1:0] wr_idx;
    logic       fill_full;
    logic       out_vld_q;
    logic       err_q;
    logic       accept;
    logic       drain;
    logic       out_free;
    logic       complete;

    always_comb begin
        in_smp.re = bus.s_real;
        in_smp.im = bus.s_imag;
        accept    = bus.s_valid & ~fill_full;
        drain     = out_vld_q & bus.out_ready;
        out_free  = ~out_vld_q | drain;
        // s_first restarts the frame at slot 0 regardless of the current count
        wr_idx    = bus.s_first ? 2'd0 : count;
        complete  = accept & (wr_idx == 2'd3);
        for (int i = 0; i < 4; i++) begin
            frame[i] = fill_bank[i];
        end
        frame[3]  = in_smp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fill_bank[i] <= '0;
                out_bank[i]  <= '0;
            end
            count     <= 2'd0;
            fill_full <= 1'b0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                fill_bank[wr_idx] <= in_smp;
                err_q             <= bus.s_first & (count != 2'd0);
                count             <= wr_idx + 2'd1;
                if (complete && !out_free) begin
                    fill_full <= 1'b1;
                end
            end
            if (complete && out_free) begin
                out_bank  <= frame;
                out_vld_q <= 1'b1;
            end else if (fill_full && drain) begin
                out_bank  <= fill_bank;
                out_vld_q <= 1'b1;
                fill_full <= 1'b0;
            end else if (drain) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.s_ready    = ~fill_full;
    assign bus.out_valid  = out_vld_q;
    assign bus.err_align  = err_q;
    assign bus.real_out_0 = out_bank[0].re;
    assign bus.real_out_1 = out_bank[1].re;
    assign bus.real_out_2 = out_bank[2].re;
    assign bus.real_out_3 = out_bank[3].re;
    assign bus.imag_out_0 = out_bank[0].im;
    assign bus.imag_out_1 = out_bank[1].im;
    assign bus.imag_out_2 = out_bank[2].im;
    assign bus.imag_out_3 = out_bank[3].im;
endmodule

// File: tb/tb_fft4_in_collector.sv
// Scoreboard bench for fft4_in_collector: accepted samples build expected frames in a queue,
// checked every cycle against the presented output bank.
module tb_fft4_in_collector;
    localparam int DW = 8;

    typedef struct {
        int re[4];
        int im[4];
    } frame_t;

    logic clk;
    logic rst_n;

    fft4_in_collector_if #(.DATA_W(DW)) bus ();

    fft4_in_collector #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t q[$];
    frame_t cur;
    frame_t f;
    int     m_cnt   = 0;
    int     idx;
    bit     exp_err = 0;
    bit     acc;
    bit     drn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare current outputs with the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt   = 0;
            exp_err = 0;
        end else begin
            check_eq("s_ready",   int'(bus.s_ready),   int'(q.size() < 2));
            check_eq("out_valid", int'(bus.out_valid), int'(q.size() > 0));
            check_eq("err_align", int'(bus.err_align), int'(exp_err));
            if (q.size() > 0) begin
                f = q[0];
                check_eq("real_out_0", int'(bus.real_out_0), f.re[0]);
                check_eq("real_out_1", int'(bus.real_out_1), f.re[1]);
                check_eq("real_out_2", int'(bus.real_out_2), f.re[2]);
                check_eq("real_out_3", int'(bus.real_out_3), f.re[3]);
                check_eq("imag_out_0", int'(bus.imag_out_0), f.im[0]);
                check_eq("imag_out_1", int'(bus.imag_out_1), f.im[1]);
                check_eq("imag_out_2", int'(bus.imag_out_2), f.im[2]);
                check_eq("imag_out_3", int'(bus.imag_out_3), f.im[3]);
            end
            acc     = bus.s_valid && (q.size() < 2);
            drn     = (q.size() > 0) && bus.out_ready;
            exp_err = acc && bus.s_first && (m_cnt != 0);
            if (drn) void'(q.pop_front());
            if (acc) begin
                idx         = bus.s_first ? 0 : m_cnt;
                cur.re[idx] = int'(bus.s_real);
                cur.im[idx] = int'(bus.s_imag);
                if (idx == 3) begin
                    q.push_back(cur);
                    m_cnt = 0;
                end else begin
                    m_cnt = idx + 1;
                end
            end
        end
    end

    task automatic send(input int re, input int im, input bit first);
        int guard = 0;
        bit ok    = 0;
        bus.s_valid = 1'b1;
        bus.s_real  = DW'(re);
        bus.s_imag  = DW'(im);
        bus.s_first = first;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check_eq("send_timeout", int'(bus.s_ready), 1);
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) check_eq("drain_timeout", q.size(), 0);
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_first   = 1'b0;
        bus.s_real    = '0;
        bus.s_imag    = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n      = 1'b1;

        check_eq("rst_s_ready",   int'(bus.s_ready),    1);
        check_eq("rst_out_valid", int'(bus.out_valid),  0);
        check_eq("rst_err_align", int'(bus.err_align),  0);
        check_eq("rst_real_0",    int'(bus.real_out_0), 0);
        check_eq("rst_imag_3",    int'(bus.imag_out_3), 0);

        // single frame, latency of one cycle after the 4th accept
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(i, -i, 1'b0);
        check_eq("t1_out_valid", int'(bus.out_valid),  1);
        check_eq("t1_real_3",    int'(bus.real_out_3), 4);
        check_eq("t1_imag_1",    int'(bus.imag_out_1), -2);
        wait_empty();

        // back-to-back stream of three frames
        for (int i = 0; i < 12; i++) send(i, -i, 1'b0);
        wait_empty();
        repeat (2) @(posedge clk);
        #1;

        // backpressure: A held, B parked in fill bank
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(30 + i, -30 - i, 1'b0);
        check_eq("t3_s_ready_low", int'(bus.s_ready),    0);
        check_eq("t3_a_real_0",    int'(bus.real_out_0), 30);
        @(posedge clk);
        #1;
        check_eq("t3_a_hold_imag_3", int'(bus.imag_out_3), -33);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check_eq("t3_b_valid",   int'(bus.out_valid),  1);
        check_eq("t3_b_real_0",  int'(bus.real_out_0), 34);
        check_eq("t3_s_ready_hi", int'(bus.s_ready),   1);
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_empty();

        // realignment: partial {10,11} discarded
        send(10, -10, 1'b0);
        send(11, -11, 1'b0);
        send(20, -20, 1'b1);
        check_eq("t4_err_pulse", int'(bus.err_align), 1);
        send(21, -21, 1'b0);
        check_eq("t4_err_clear", int'(bus.err_align), 0);
        send(22, -22, 1'b0);
        send(23, -23, 1'b0);
        check_eq("t4_real_0", int'(bus.real_out_0), 20);
        wait_empty();

        // extreme values pass bit-exact
        send(-128, 127, 1'b0);
        send(127, -128, 1'b0);
        send(-128, -128, 1'b0);
        send(127, 127, 1'b0);
        check_eq("t5_real_0_bits", int'({24'd0, bus.real_out_0}), 'h80);
        check_eq("t5_imag_0_bits", int'({24'd0, bus.imag_out_0}), 'h7F);
        wait_empty();

        // asynchronous reset mid-frame with a frame presented
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(50 + i, -50 - i, 1'b0);
        check_eq("t6_pre_valid", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid",  int'(bus.out_valid),  0);
        check_eq("t6_rst_real_0", int'(bus.real_out_0), 0);
        check_eq("t6_rst_imag_2", int'(bus.imag_out_2), 0);
        check_eq("t6_rst_err",    int'(bus.err_align),  0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(60 + i, -60 - i, 1'b0);
        check_eq("t6_clean_real_0", int'(bus.real_out_0), 60);
        check_eq("t6_clean_err",    int'(bus.err_align),  0);
        wait_empty();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
